// File: rtl/cap_frame_writer_pkg.sv
// Shared definitions for the capture frame writer: FSM encoding and memory byte geometry.
package cap_frame_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam int PIX_BYTES = 4;
  localparam int ENT_BYTES = 2 * PIX_BYTES;

endpackage

// File: rtl/cap_burst_buf.sv
// Staging buffer for one burst of FIFO entries; written one entry per cycle,
// read combinationally as 24-bit pixel halves selected by the beat's low bit.
module cap_burst_buf
  import cap_frame_writer_pkg::*;
#(
  parameter int BURST_ENT = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [47:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  input  logic             rsel,
  output logic [23:0]      rdata
);

  logic [47:0] mem [BURST_ENT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Even beats carry the first pixel of the pair, odd beats the second.
  assign rdata = rsel ? mem[raddr][23:0] : mem[raddr][47:24];

endmodule

// File: rtl/cap_frame_writer.sv
// Drains RGB888 pixel pairs from the capture FIFO and writes each frame to memory
// as bursts of {8'h00,R,G,B} beats, one burst outstanding at a time.
module cap_frame_writer
  import cap_frame_writer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BURST_ENT = 8,
  parameter int CNT_W     = 20
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  FRAME_ENT,
  input  logic              FIFO_EMPTY,
  input  logic              FIFO_FULL,
  output logic              FIFO_RD,
  input  logic [47:0]       FIFO_DOUT,
  output logic              MEM_AWVALID,
  input  logic              MEM_AWREADY,
  output logic [ADDR_W-1:0] MEM_AWADDR,
  output logic [7:0]        MEM_AWLEN,
  output logic              MEM_WVALID,
  input  logic              MEM_WREADY,
  output logic [31:0]       MEM_WDATA,
  output logic              MEM_WLAST,
  input  logic              MEM_BVALID,
  output logic              MEM_BREADY,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW
);

  localparam int ENT_W  = $clog2(BURST_ENT + 1);
  localparam int IDX_W  = (BURST_ENT > 1) ? $clog2(BURST_ENT) : 1;
  localparam int BEAT_W = IDX_W + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [ENT_W-1:0]  rd_cnt_q, cap_cnt_q, burst_n;
  logic [BEAT_W-1:0] beat_q, last_beat;
  logic [8:0]        two_n;
  logic              rd_vld_p1, done_q, ovf_q;
  logic              start_acc, last_burst, w_xfer, b_xfer;
  logic [23:0]       pix;

  function automatic logic [ENT_W-1:0] sat_burst(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(BURST_ENT)) return ENT_W'(BURST_ENT);
    return rem[ENT_W-1:0];
  endfunction

  assign burst_n    = sat_burst(remaining_q);
  assign two_n      = 9'({burst_n, 1'b0});
  assign last_beat  = BEAT_W'(two_n - 9'd1);
  assign last_burst = (remaining_q == CNT_W'(burst_n));
  // A START landing on the DONE cycle belongs to the frame just finished, so drop it.
  assign start_acc  = START && (state_q == S_IDLE) && !done_q;
  assign w_xfer     = MEM_WVALID && MEM_WREADY;
  assign b_xfer     = (state_q == S_RESP) && MEM_BVALID;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    FIFO_RD     = 1'b0;
    MEM_AWVALID = 1'b0;
    MEM_WVALID  = 1'b0;
    MEM_BREADY  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc && (FRAME_ENT != '0)) state_d = S_FILL;
      end
      S_FILL: begin
        FIFO_RD = !FIFO_EMPTY && (rd_cnt_q < burst_n);
        if (rd_vld_p1 && ((cap_cnt_q + ENT_W'(1)) == burst_n)) state_d = S_ADDR;
      end
      S_ADDR: begin
        MEM_AWVALID = 1'b1;
        if (MEM_AWREADY) state_d = S_DATA;
      end
      S_DATA: begin
        MEM_WVALID = 1'b1;
        if (MEM_WREADY && (beat_q == last_beat)) state_d = S_RESP;
      end
      S_RESP: begin
        MEM_BREADY = 1'b1;
        if (MEM_BVALID) state_d = last_burst ? S_IDLE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // p1: FIFO data lands one cycle after the read strobe and is captured here
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_vld_p1   <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rd_cnt_q    <= '0;
      cap_cnt_q   <= '0;
      beat_q      <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      rd_vld_p1 <= FIFO_RD;
      done_q    <= (start_acc && (FRAME_ENT == '0)) || (b_xfer && last_burst);
      if (start_acc)              ovf_q <= 1'b0;
      else if (BUSY && FIFO_FULL) ovf_q <= 1'b1;
      if (FIFO_RD)   rd_cnt_q  <= rd_cnt_q + ENT_W'(1);
      if (rd_vld_p1) cap_cnt_q <= cap_cnt_q + ENT_W'(1);
      if (MEM_AWVALID) beat_q <= '0;
      else if (w_xfer) beat_q <= beat_q + BEAT_W'(1);
      if (start_acc) begin
        cur_addr_q  <= BASE_ADDR;
        remaining_q <= FRAME_ENT;
        rd_cnt_q    <= '0;
        cap_cnt_q   <= '0;
      end else if (b_xfer) begin
        cur_addr_q  <= cur_addr_q + ADDR_W'(ENT_BYTES) * ADDR_W'(burst_n);
        remaining_q <= remaining_q - CNT_W'(burst_n);
        rd_cnt_q    <= '0;
        cap_cnt_q   <= '0;
      end
    end
  end

  cap_burst_buf #(
    .BURST_ENT(BURST_ENT),
    .IDX_W    (IDX_W)
  ) u_buf (
    .clk  (CLK),
    .we   (rd_vld_p1),
    .waddr(cap_cnt_q[IDX_W-1:0]),
    .wdata(FIFO_DOUT),
    .raddr(beat_q[BEAT_W-1:1]),
    .rsel (beat_q[0]),
    .rdata(pix)
  );

  // Payload outputs are forced low outside their valid window so reset shows all zeros.
  assign MEM_AWADDR = MEM_AWVALID ? cur_addr_q : '0;
  assign MEM_AWLEN  = MEM_AWVALID ? 8'(two_n - 9'd1) : 8'd0;
  assign MEM_WDATA  = MEM_WVALID ? {8'h00, pix} : 32'd0;
  assign MEM_WLAST  = MEM_WVALID && (beat_q == last_beat);
  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_cap_frame_writer.sv
// Directed bench for cap_frame_writer: a FIFO/memory responder plus a scoreboard of
// expected bursts and beats built from the same pixel words fed into the FIFO.
`timescale 1ns/1ps
module tb_cap_frame_writer;

  localparam int ADDR_W    = 32;
  localparam int BURST_ENT = 8;
  localparam int CNT_W     = 20;

  logic              CLK, RST_N, START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [CNT_W-1:0]  FRAME_ENT;
  logic              FIFO_EMPTY, FIFO_FULL, FIFO_RD;
  logic [47:0]       FIFO_DOUT;
  logic              MEM_AWVALID, MEM_AWREADY;
  logic [ADDR_W-1:0] MEM_AWADDR;
  logic [7:0]        MEM_AWLEN;
  logic              MEM_WVALID, MEM_WREADY, MEM_WLAST;
  logic [31:0]       MEM_WDATA;
  logic              MEM_BVALID, MEM_BREADY;
  logic              BUSY, DONE, OVERFLOW;

  cap_frame_writer #(
    .ADDR_W(ADDR_W), .BURST_ENT(BURST_ENT), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .FRAME_ENT(FRAME_ENT),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_FULL(FIFO_FULL), .FIFO_RD(FIFO_RD), .FIFO_DOUT(FIFO_DOUT),
    .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY), .MEM_AWADDR(MEM_AWADDR),
    .MEM_AWLEN(MEM_AWLEN), .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WLAST(MEM_WLAST), .MEM_BVALID(MEM_BVALID),
    .MEM_BREADY(MEM_BREADY), .BUSY(BUSY), .DONE(DONE), .OVERFLOW(OVERFLOW)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [47:0] fifo_q [$];
  logic [39:0] exp_aw [$];
  logic [32:0] exp_w  [$];

  int checks = 0;
  int errors = 0;
  int stall_pct = 0;
  logic rd_pend = 1'b0;
  int b_owed = 0;
  int rd_tot = 0, w_tot = 0, aw_tot = 0, done_tot = 0;
  int b_cyc = 0, done_cyc = 0;
  logic ovf_at_done = 1'b0;
  logic aw_hold = 1'b0, w_hold = 1'b0;
  logic [40:0] aw_held;
  logic [33:0] w_held;
  int rd0, w0, aw0, done0, s_cyc, cur_ent;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rnd_rdy();
    return (stall_pct == 0) || (int'($urandom_range(99)) >= stall_pct);
  endfunction

  function automatic logic [127:0] outs();
    return 128'({FIFO_RD, MEM_AWVALID, MEM_AWADDR, MEM_AWLEN, MEM_WVALID, MEM_WDATA,
                 MEM_WLAST, MEM_BREADY, BUSY, DONE, OVERFLOW});
  endfunction

  // FIFO and memory responder; inputs change on the falling edge, and whatever
  // valid/ready pairs are seen 1 ns later are the transfers of the next rising edge.
  task automatic responder();
    logic [39:0] ea;
    logic [32:0] ew;
    forever begin
      @(negedge CLK);
      if (rd_pend) begin
        if (fifo_q.size() > 0) FIFO_DOUT = fifo_q.pop_front();
        rd_pend = 1'b0;
      end
      FIFO_EMPTY  = (fifo_q.size() == 0) ||
                    ((stall_pct > 0) && (int'($urandom_range(99)) < stall_pct));
      MEM_AWREADY = rnd_rdy();
      MEM_WREADY  = rnd_rdy();
      MEM_BVALID  = (b_owed > 0) && rnd_rdy();
      #1;
      if (RST_N) begin
        if (FIFO_RD) begin
          chk("rd_when_empty", FIFO_EMPTY, 0);
          rd_pend = 1'b1;
          rd_tot++;
        end
        if (MEM_AWVALID || MEM_WVALID) chk("aw_w_overlap", MEM_AWVALID && MEM_WVALID, 0);
        if (aw_hold) chk("aw_stable", {MEM_AWVALID, MEM_AWADDR, MEM_AWLEN}, aw_held);
        aw_hold = 1'b0;
        if (MEM_AWVALID) begin
          if (MEM_AWREADY) begin
            aw_tot++;
            if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
              ea = exp_aw.pop_front();
              chk("aw_addr", MEM_AWADDR, ea[39:8]);
              chk("aw_len", MEM_AWLEN, ea[7:0]);
            end
          end else begin
            aw_hold = 1'b1;
            aw_held = {1'b1, MEM_AWADDR, MEM_AWLEN};
          end
        end
        if (w_hold) chk("w_stable", {MEM_WVALID, MEM_WDATA, MEM_WLAST}, w_held);
        w_hold = 1'b0;
        if (MEM_WVALID) begin
          if (MEM_WREADY) begin
            w_tot++;
            if (MEM_WLAST) b_owed++;
            if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
            else begin
              ew = exp_w.pop_front();
              chk("w_beat", {MEM_WDATA, MEM_WLAST}, ew);
            end
          end else begin
            w_hold = 1'b1;
            w_held = {1'b1, MEM_WDATA, MEM_WLAST};
          end
        end
        if (MEM_BVALID && MEM_BREADY) begin
          b_owed--;
          b_cyc = cyc;
        end
        if (DONE) begin
          done_tot++;
          done_cyc    = cyc;
          ovf_at_done = OVERFLOW;
          chk("busy_at_done", BUSY, 0);
        end
      end
    end
  endtask

  task automatic begin_frame(input logic [31:0] base, input int ent,
                             input logic [47:0] w0word, input logic use_w0);
    logic [47:0] words [$];
    logic [63:0] r;
    logic [31:0] a;
    int rem, n, idx;
    for (int i = 0; i < ent; i++) begin
      r = {$urandom(), $urandom()};
      words.push_back((i == 0 && use_w0) ? w0word : r[47:0]);
    end
    foreach (words[i]) fifo_q.push_back(words[i]);
    rem = ent; a = base; idx = 0;
    while (rem > 0) begin
      n = (rem > BURST_ENT) ? BURST_ENT : rem;
      exp_aw.push_back({a, 8'(2 * n - 1)});
      for (int b = 0; b < 2 * n; b++)
        exp_w.push_back({((b % 2) == 0) ? {8'h00, words[idx + b / 2][47:24]}
                                        : {8'h00, words[idx + b / 2][23:0]},
                         (b == 2 * n - 1)});
      idx += n; rem -= n; a = a + 32'(8 * n);
    end
    rd0 = rd_tot; w0 = w_tot; aw0 = aw_tot; done0 = done_tot; cur_ent = ent;
    @(negedge CLK);
    BASE_ADDR = base; FRAME_ENT = CNT_W'(ent); START = 1'b1; s_cyc = cyc;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic finish_frame(input logic exp_ovf);
    int to = 0;
    while (done_tot == done0 && to < 4000) begin
      @(negedge CLK); #2; to++;
    end
    chk("done_seen", done_tot - done0, 1);
    if (cur_ent == 0) chk("done_timing", done_cyc, s_cyc + 1);
    else              chk("done_timing", done_cyc, b_cyc + 1);
    chk("rd_count", rd_tot - rd0, cur_ent);
    chk("beat_count", w_tot - w0, 2 * cur_ent);
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
    chk("ovf_at_done", ovf_at_done, exp_ovf);
    @(negedge CLK); #2;
    chk("done_pulse", DONE, 0);
  endtask

  initial begin
    int to;
    RST_N = 1'b0; START = 1'b0; BASE_ADDR = '0; FRAME_ENT = '0;
    FIFO_EMPTY = 1'b1; FIFO_FULL = 1'b0; FIFO_DOUT = '0;
    MEM_AWREADY = 1'b0; MEM_WREADY = 1'b0; MEM_BVALID = 1'b0;
    fork
      responder();
    join_none
    repeat (3) @(negedge CLK);
    #2 chk("reset_outputs", outs(), 0);
    RST_N = 1'b1;

    // two full bursts, no stalls
    stall_pct = 0;
    begin_frame(32'h1000_0000, 16, 48'h0, 1'b0);
    finish_frame(1'b0);
    chk("t2_bursts", aw_tot - aw0, 2);

    // short final burst and known pixel order
    begin_frame(32'h2000_0100, 11, 48'h112233_445566, 1'b1);
    finish_frame(1'b0);
    chk("t3_bursts", aw_tot - aw0, 2);

    // random stalls, FIFO gaps, address wrap through zero
    stall_pct = 35;
    begin_frame(32'hFFFF_FF80, 27, 48'h0, 1'b0);
    finish_frame(1'b0);
    chk("t4_bursts", aw_tot - aw0, 4);

    // empty frame, then START while busy
    stall_pct = 0;
    begin_frame(32'h3000_0000, 0, 48'h0, 1'b0);
    finish_frame(1'b0);
    chk("t5_no_aw", aw_tot - aw0, 0);
    begin_frame(32'h3000_0000, 8, 48'h0, 1'b0);
    repeat (4) @(negedge CLK);
    FRAME_ENT = CNT_W'(4); START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    finish_frame(1'b0);

    // overflow is sticky through DONE and cleared by the next START
    stall_pct = 20;
    begin_frame(32'h4000_0000, 12, 48'h0, 1'b0);
    repeat (6) @(negedge CLK);
    FIFO_FULL = 1'b1;
    @(negedge CLK);
    FIFO_FULL = 1'b0;
    finish_frame(1'b1);
    begin_frame(32'h4000_1000, 2, 48'h0, 1'b0);
    #2 chk("t6_ovf_cleared", OVERFLOW, 0);
    finish_frame(1'b0);

    // reset during a data burst
    stall_pct = 30;
    begin_frame(32'h5000_0000, 16, 48'h0, 1'b0);
    to = 0;
    while (MEM_WVALID !== 1'b1 && to < 2000) begin
      @(negedge CLK); #2; to++;
    end
    chk("t1_in_data", MEM_WVALID, 1);
    RST_N = 1'b0;
    #1 chk("t1_reset_outputs", outs(), 0);
    fifo_q.delete(); exp_aw.delete(); exp_w.delete();
    rd_pend = 1'b0; b_owed = 0; aw_hold = 1'b0; w_hold = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK); #2;
    chk("t1_idle_after_reset", {BUSY, DONE, MEM_AWVALID, MEM_WVALID}, 0);
    stall_pct = 0;
    begin_frame(32'h6000_0000, 3, 48'h0, 1'b0);
    finish_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
